sonar_scheduler: RTL and testbench
==================================

Name: sonar_scheduler

Overview:
- Time-multiplexes NUM_SONAR SR04-style sonar front ends so that only one transducer is pinging at a time, which prevents acoustic crosstalk.
- Walks the enabled sonars round-robin:
  - pulses the active unit's sync input;
  - waits for its valid strobe or a slot timeout;
  - banks the 8-bit result, then holds an inter-ping gap.
- Sits between the sonar front ends and the register interface peripheral, which reads the result bank and the flags.

Parameters:
- NUM_SONAR, 4: number of sonar front ends (1..8).
- SLOT_CYCLES, 1_500_000: maximum clocks spent waiting for a result per slot (30 ms at 50 MHz).
- GAP_CYCLES, 500_000: quiet clocks between slots for echo decay (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- en  in  1  scheduler enable.
- en_mask  in  NUM_SONAR  per-sonar enable; bit i=1 includes sonar i in the rotation.
- sync  out  NUM_SONAR  one-cycle start pulse to sonar i.
- valid_in  in  NUM_SONAR  result strobe from sonar i.
- dist_in  in  8*NUM_SONAR  result from sonar i at bits [8i+7:8i].
- dist_out  out  8*NUM_SONAR  banked last result per sonar.
- new_data  out  NUM_SONAR  sticky flag: bit i is set when dist_out for sonar i is updated.
- clr_new  in  NUM_SONAR  clears the matching new_data bits.
- timeout  out  NUM_SONAR  sticky flag: bit i is set when sonar i's last slot timed out; cleared when sonar i delivers a valid result.
- active_idx  out  3  index of the sonar currently owning the slot.
- busy  out  1  high in every state except IDLE.
- cycle_done  out  1  one-cycle pulse when the rotation wraps.

Behaviour:
- Reset values: all outputs 0, except dist_out, which resets to all 0x00. The internal last index resets to NUM_SONAR-1, so the first pick is the lowest enabled index.
- State IDLE:
  - If en=1 and en_mask is nonzero, go to SELECT.
- State SELECT (1 cycle):
  - Pick the next index with its en_mask bit set, searching upward from last+1 with wrap-around.
  - If the mask is 0, go to IDLE.
  - cycle_done pulses in this cycle when picked index <= previous index. A single enabled sonar therefore pulses every slot. The first pick after reset does not pulse.
  - Latch the pick into active_idx, then go to FIRE.
- State FIRE (1 cycle):
  - sync[active_idx]=1; all other sync bits are 0.
  - Clear slot_cnt, then go to WAIT.
- State WAIT:
  - slot_cnt increments every cycle.
  - If valid_in[active_idx]=1:
    - dist_out[active_idx] <= dist_in slice;
    - set new_data bit;
    - clear timeout bit;
    - go to GAP.
  - Else if slot_cnt == SLOT_CYCLES-1:
    - set timeout bit;
    - dist_out[active_idx] <= 8'hFF;
    - set new_data bit;
    - go to GAP.
  - A valid arriving in the same cycle as the timeout wins; no timeout is flagged.
- State GAP:
  - Count GAP_CYCLES clocks, then go to SELECT.
- Ignored inputs: valid_in on any non-active index is ignored in every state. valid_in outside WAIT is ignored.
- Disable or mask change:
  - en=0 in any state → IDLE at the next edge. sync goes to 0. dist_out, new_data and timeout are preserved. An in-flight result is discarded.
  - Clearing en_mask[active_idx] mid-slot does not abort the slot. The mask is only sampled in SELECT.
- Flag clear: clr_new[i] and a new_data set for i in the same cycle → set wins.
- Reset mid-operation: returns to IDLE on the next edge with all reset values; sync drops immediately on that edge.
- Counter widths: $clog2 of the respective parameter, or 1 bit minimum. Counters never wrap in normal operation.
- Latency:
  - en rising → sync pulse 2 cycles later (IDLE→SELECT→FIRE).
  - valid_in → dist_out and new_data visible 1 cycle later.

Test Plan (NUM_SONAR=4, SLOT_CYCLES=100, GAP_CYCLES=10):
- Round robin: en_mask=4'b1011, en=1, each sonar returns valid 20 cycles after its sync with dist 0x10/0x20/–/0x40 → sync order 0,1,3,0; dist_out banked 0x10, 0x20, 0x00, 0x40; cycle_done pulses once per wrap.
- Timeout: sonar 2 never responds → exactly 100 WAIT cycles; timeout[2]=1, dist_out[2]=0xFF, new_data[2]=1. A later valid with 0x33 → timeout[2]=0, dist_out[2]=0x33.
- Foreign strobe: valid_in[1] with dist 0x77 while sonar 0 is active → dist_out[1] unchanged, new_data[1]=0.
- Simultaneous events: valid on timeout cycle → no timeout, value captured. clr_new[0] in the same cycle as new_data[0] set → new_data[0]=1.
- Disable mid-WAIT: en=0 → busy=0 the next cycle and dist_out retained. en=1 → resumes at the next enabled index.
- Reset in GAP: all outputs return to reset values. The next run starts at the lowest enabled index with no cycle_done on the first pick.

Source files
------------

// File: rtl/sonar_scheduler_if.sv
// Bus between the sonar scheduler, the sonar front ends and the register
// peripheral.
//   master : peripheral / front-end side (drives enables, strobes, results, clears)
//   slave  : scheduler side (drives sync pulses, result bank, flags, status)
// Signals:
//   en, en_mask     scheduler enable and per-sonar rotation mask
//   sync            one-cycle start pulse per sonar
//   valid_in        result strobe per sonar
//   dist_in         8-bit result per sonar, sonar i at [8i+7:8i]
//   dist_out        banked last result per sonar
//   new_data        sticky "result updated" flags
//   clr_new         clears matching new_data bits
//   timeout         sticky "last slot timed out" flags
//   active_idx      sonar currently owning the slot
//   busy            scheduler not idle
//   cycle_done      one-cycle pulse when the rotation wraps
interface sonar_scheduler_if #(
   parameter int NUM_SONAR = 4
);
   logic                   en;
   logic [NUM_SONAR-1:0]   en_mask;
   logic [NUM_SONAR-1:0]   sync;
   logic [NUM_SONAR-1:0]   valid_in;
   logic [8*NUM_SONAR-1:0] dist_in;
   logic [8*NUM_SONAR-1:0] dist_out;
   logic [NUM_SONAR-1:0]   new_data;
   logic [NUM_SONAR-1:0]   clr_new;
   logic [NUM_SONAR-1:0]   timeout;
   logic [2:0]             active_idx;
   logic                   busy;
   logic                   cycle_done;

   modport master (
      output en, en_mask, valid_in, dist_in, clr_new,
      input  sync, dist_out, new_data, timeout, active_idx, busy, cycle_done
   );

   modport slave (
      input  en, en_mask, valid_in, dist_in, clr_new,
      output sync, dist_out, new_data, timeout, active_idx, busy, cycle_done
   );
endinterface

// File: rtl/sonar_scheduler.sv
// Round-robin ping scheduler for SR04-style sonar front ends. Only one
// transducer pings at a time: the active sonar gets a sync pulse, the
// scheduler waits for its result or a slot timeout, banks the value and
// then holds a quiet gap so echoes decay before the next sonar fires.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    sonar_scheduler_if slave modport (see interface header)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | disabled or empty mask, waiting for en and a nonzero mask
// SELECT | pick next enabled sonar after the last one (wraps)
// FIRE   | one-cycle sync pulse to the picked sonar
// WAIT   | waiting for the sonar's valid strobe or slot timeout
// GAP    | quiet time for echo decay before the next pick
module sonar_scheduler #(
   parameter int NUM_SONAR   = 4,
   parameter int SLOT_CYCLES = 1_500_000,
   parameter int GAP_CYCLES  = 500_000
) (
   input  logic clk,
   input  logic reset,
   sonar_scheduler_if.slave bus
);

   localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_FIRE   = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;

   logic [2:0]             state;
   logic [2:0]             last_idx;
   logic [2:0]             active_idx;
   logic                   first_pick;
   logic [SLOT_W-1:0]      slot_cnt;
   logic [GAP_W-1:0]       gap_cnt;
   logic [8*NUM_SONAR-1:0] dist_q;
   logic [NUM_SONAR-1:0]   new_q;
   logic [NUM_SONAR-1:0]   to_q;

   logic [7:0]             mask8;
   logic [3:0]             cand;
   logic [2:0]             pick_idx;
   logic                   pick_found;
   logic [NUM_SONAR-1:0]   act_vec;
   logic                   valid_act;
   logic [7:0]             dist_sel;
   logic                   in_wait;
   logic                   slot_end;
   logic                   capture;
   logic                   expire;
   logic                   bank_en;
   logic [7:0]             bank_val;

   // Search downward over offsets so the smallest offset from last_idx wins.
   always_comb begin
      mask8      = 8'(bus.en_mask);
      cand       = '0;
      pick_idx   = last_idx;
      pick_found = 1'b0;
      for (int k = NUM_SONAR; k >= 1; k--) begin
         cand = {1'b0, last_idx} + 4'(k);
         if (cand >= 4'(NUM_SONAR))
            cand = cand - 4'(NUM_SONAR);
         if (mask8[cand[2:0]]) begin
            pick_idx   = cand[2:0];
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      act_vec   = '0;
      valid_act = 1'b0;
      dist_sel  = 8'h00;
      for (int i = 0; i < NUM_SONAR; i++) begin
         if (active_idx == 3'(i)) begin
            act_vec[i] = 1'b1;
            valid_act  = bus.valid_in[i];
            dist_sel   = bus.dist_in[8*i +: 8];
         end
      end
   end

   // en low discards whatever the sonar delivers in the same cycle.
   assign in_wait  = (state == ST_WAIT) && bus.en;
   assign slot_end = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
   assign capture  = in_wait && valid_act;
   assign expire   = in_wait && !valid_act && slot_end;
   assign bank_en  = capture || expire;
   assign bank_val = capture ? dist_sel : 8'hFF;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_idx   <= 3'(NUM_SONAR - 1);
         active_idx <= 3'd0;
         first_pick <= 1'b1;
         slot_cnt   <= '0;
         gap_cnt    <= '0;
         dist_q     <= '0;
         new_q      <= '0;
         to_q       <= '0;
      end else begin
         new_q <= (new_q & ~bus.clr_new) | (bank_en ? act_vec : '0);
         to_q  <= (to_q & ~(capture ? act_vec : '0)) | (expire ? act_vec : '0);
         for (int i = 0; i < NUM_SONAR; i++) begin
            if (bank_en && (active_idx == 3'(i)))
               dist_q[8*i +: 8] <= bank_val;
         end

         if (!bus.en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (|bus.en_mask)
                     state <= ST_SELECT;
               end
               ST_SELECT: begin
                  if (pick_found) begin
                     active_idx <= pick_idx;
                     last_idx   <= pick_idx;
                     first_pick <= 1'b0;
                     state      <= ST_FIRE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_FIRE: begin
                  slot_cnt <= '0;
                  state    <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (valid_act || slot_end) begin
                     gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                     state   <= ST_GAP;
                  end else begin
                     slot_cnt <= slot_cnt + SLOT_W'(1);
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == '0)
                     state <= ST_SELECT;
                  else
                     gap_cnt <= gap_cnt - GAP_W'(1);
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.sync       = (state == ST_FIRE) ? act_vec : '0;
   assign bus.dist_out   = dist_q;
   assign bus.new_data   = new_q;
   assign bus.timeout    = to_q;
   assign bus.active_idx = active_idx;
   assign bus.busy       = (state != ST_IDLE);
   // Wrap detection: picked index not above the previous one; the very
   // first pick after reset is not a wrap.
   assign bus.cycle_done = (state == ST_SELECT) && bus.en && pick_found &&
                           !first_pick && (pick_idx <= last_idx);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Testbench for sonar_scheduler (NUM_SONAR=4, SLOT_CYCLES=100, GAP_CYCLES=10).
// The bench plays the sonar front ends on a slot timeline: each slot starts
// at the sync pulse, the result (or its absence) fixes when the slot ends,
// and the next sync follows after the gap. Expected flags/results are kept
// as per-sonar arrays and compared every cycle.
module tb_sonar_scheduler;
   localparam int N    = 4;
   localparam int SLOT = 100;
   localparam int GAP  = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sonar_scheduler_if #(.NUM_SONAR(N)) bif ();

   sonar_scheduler #(.NUM_SONAR(N), .SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_sync, exp_new, exp_to, pend_set;
   logic       exp_busy, exp_cd;
   logic [7:0] exp_dist [N];
   int         m_last;
   bit         m_first;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      exp_sync = '0; exp_new = '0; exp_to = '0; pend_set = '0;
      exp_busy = 1'b0; exp_cd = 1'b0;
      for (int i = 0; i < N; i++) exp_dist[i] = 8'h00;
      m_last  = N - 1;
      m_first = 1'b1;
   endtask

   // Round-robin rule: first enabled index above the last one, wrapping.
   task automatic next_pick(input logic [3:0] mask, output int pick, output bit cd);
      pick = -1;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (m_last + k) % N;
         if (mask[j] && pick < 0) pick = j;
      end
      cd      = !m_first && (pick <= m_last);
      m_last  = pick;
      m_first = 1'b0;
   endtask

   // One clock: apply clear/set to the flag model, move to the next
   // negedge and compare every observable output.
   task automatic cyc(input logic [3:0] force_clr);
      logic [3:0] c;
      c = force_clr;
      if ($urandom_range(0, 7) == 0) c = c | 4'($urandom);
      bif.clr_new = c;
      if (reset) exp_new = '0;
      else       exp_new = (exp_new & ~c) | pend_set;
      pend_set = '0;
      @(negedge clk);
      check("sync",       32'(bif.sync),       32'(exp_sync));
      check("cycle_done", 32'(bif.cycle_done), 32'(exp_cd));
      check("busy",       32'(bif.busy),       32'(exp_busy));
      check("new_data",   32'(bif.new_data),   32'(exp_new));
      check("timeout",    32'(bif.timeout),    32'(exp_to));
      check("dist_out",   bif.dist_out, {exp_dist[3], exp_dist[2], exp_dist[1], exp_dist[0]});
   endtask

   task automatic idle(input int n);
      bif.valid_in = '0;
      exp_busy = 1'b0; exp_sync = '0; exp_cd = 1'b0;
      repeat (n) cyc('0);
   endtask

   // From IDLE: en rises, SELECT next cycle, sync the cycle after.
   task automatic start(input logic [3:0] mask, output int idx);
      bit cd;
      bif.en = 1'b1; bif.en_mask = mask; bif.valid_in = '0;
      next_pick(mask, idx, cd);
      exp_busy = 1'b1; exp_cd = cd; exp_sync = '0;
      cyc('0);
      exp_cd = 1'b0; exp_sync = 4'(1) << idx;
      cyc('0);
   endtask

   // Entered at the FIRE negedge. delay = cycles after sync at which the
   // sonar strobes (>SLOT means too late). Ends at the first GAP negedge,
   // or at IDLE when disabled at cycle dis_t.
   task automatic run_slot(input int idx, input int delay, input logic [7:0] val,
                           input int fidx, input bit clr_on_set, input int dis_t,
                           output bit disabled);
      int end_t, fpos;
      logic [3:0] fc;
      disabled = 1'b0;
      check("active_idx", 32'(bif.active_idx), 32'(idx));
      end_t = (delay <= SLOT) ? delay : SLOT;
      fpos  = $urandom_range(1, end_t);
      for (int t = 0; t <= end_t; t++) begin
         bif.dist_in  = $urandom;
         bif.valid_in = '0;
         if (t == delay || t == dis_t) begin
            bif.valid_in[idx] = 1'b1;
            bif.dist_in[8*idx +: 8] = (t == delay) ? val : 8'hAB;
         end
         if (fidx >= 0 && t == fpos) begin
            bif.valid_in[fidx] = 1'b1;
            bif.dist_in[8*fidx +: 8] = 8'h77;
         end
         exp_sync = '0; exp_cd = 1'b0; exp_busy = 1'b1;
         if (t == dis_t) begin
            bif.en = 1'b0;
            exp_busy = 1'b0;
            cyc('0);
            disabled = 1'b1;
            return;
         end
         fc = '0;
         if (t == end_t) begin
            if (delay <= SLOT) begin
               exp_dist[idx] = val; exp_to[idx] = 1'b0;
            end else begin
               exp_dist[idx] = 8'hFF; exp_to[idx] = 1'b1;
            end
            pend_set[idx] = 1'b1;
            if (clr_on_set) fc[idx] = 1'b1;
         end
         cyc(fc);
      end
   endtask

   // Entered at the first GAP negedge; GAP cycles, SELECT, then FIRE.
   // late >= 0 strobes that sonar in the first gap cycle (must be ignored).
   task automatic gap_select(input int late, output int idx);
      bit cd;
      next_pick(bif.en_mask, idx, cd);
      for (int k = 1; k <= GAP + 1; k++) begin
         bif.valid_in = '0;
         bif.dist_in  = $urandom;
         if (k == 1 && late >= 0) bif.valid_in[late] = 1'b1;
         exp_busy = 1'b1;
         exp_cd   = (k == GAP) ? cd : 1'b0;
         exp_sync = (k == GAP + 1) ? (4'(1) << idx) : '0;
         cyc('0);
      end
   endtask

   initial begin
      int idx, delay, fidx, dis_t, r;
      bit dis;
      logic [7:0] val;

      reset = 1'b1;
      bif.en = 1'b0; bif.en_mask = '0; bif.valid_in = '0;
      bif.dist_in = '0; bif.clr_new = '0;
      model_reset();
      repeat (3) cyc('0);
      check("reset_active_idx", 32'(bif.active_idx), 32'd0);
      reset = 1'b0;
      idle(2);

      // Round robin over 0,1,3 with a foreign strobe on sonar 1 during slot 0.
      start(4'b1011, idx);
      run_slot(idx, 20, 8'h10, 1, 1'b0, -1, dis);
      gap_select(-1, idx);
      run_slot(idx, 20, 8'h20, -1, 1'b0, -1, dis);
      gap_select(-1, idx);
      run_slot(idx, 20, 8'h40, -1, 1'b0, -1, dis);
      gap_select(-1, idx);
      // Mask change mid-slot: slot 0 still completes, next pick uses new mask.
      bif.en_mask = 4'b0100;
      run_slot(idx, 20, 8'h11, -1, 1'b0, -1, dis);
      gap_select(-1, idx);
      // Sonar 2 silent: full-length slot and timeout.
      run_slot(idx, 300, 8'h00, -1, 1'b0, -1, dis);
      gap_select(-1, idx);
      // Strobe one cycle after the timeout cycle is ignored.
      run_slot(idx, SLOT + 1, 8'h55, -1, 1'b0, -1, dis);
      gap_select(idx, idx);
      // Strobe on the timeout cycle wins, with clr_new in the same cycle.
      run_slot(idx, SLOT, 8'h33, 0, 1'b1, -1, dis);
      gap_select(-1, idx);
      // Disable mid-WAIT with a strobe in the same cycle: result discarded.
      bif.en_mask = 4'b1111;
      run_slot(idx, 30, 8'h99, -1, 1'b0, 30, dis);
      idle(3);
      start(bif.en_mask, idx);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) bif.en_mask = 4'($urandom_range(1, 15));
         r = $urandom_range(0, 9);
         case (r)
            0:       delay = SLOT;
            1:       delay = SLOT + 1;
            2:       delay = 300;
            3:       delay = 1;
            default: delay = $urandom_range(1, SLOT - 1);
         endcase
         val   = 8'($urandom);
         fidx  = ($urandom_range(0, 1) == 0) ? (idx + $urandom_range(1, N - 1)) % N : -1;
         dis_t = ($urandom_range(0, 9) == 0)
                 ? $urandom_range(1, (delay <= SLOT) ? delay : SLOT) : -1;
         run_slot(idx, delay, val, fidx, $urandom_range(0, 1) == 1, dis_t, dis);
         if (dis) begin
            idle($urandom_range(1, 3));
            start(bif.en_mask, idx);
         end else begin
            gap_select((delay == SLOT + 1) ? idx : -1, idx);
         end
      end

      // Reset during GAP, then a fresh run from the lowest enabled index.
      run_slot(idx, 10, 8'h5A, -1, 1'b0, -1, dis);
      bif.en = 1'b0; bif.valid_in = '0;
      reset = 1'b1;
      model_reset();
      cyc('0);
      check("reset_gap_active_idx", 32'(bif.active_idx), 32'd0);
      reset = 1'b0;
      idle(1);
      start(4'b1010, idx);
      run_slot(idx, 15, 8'h21, -1, 1'b0, -1, dis);
      gap_select(-1, idx);
      run_slot(idx, 15, 8'h43, -1, 1'b0, -1, dis);
      gap_select(-1, idx);
      run_slot(idx, 15, 8'h65, -1, 1'b0, -1, dis);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
